// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   bcd_state_t     : converter FSM states
//   BCD_DIGIT_W     : bits per packed BCD digit
//   bcd_digits_for  : digit count for a given binary width. Integrators use it
//                     to size DIGITS: ceil(width * log10(2)) + 1.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } bcd_state_t;

   localparam int BCD_DIGIT_W = 4;

   // log10(2) is approximated as 0.30103. The product is never an exact
   // integer for practical widths, so the rounding-up division gives the ceiling.
   function automatic int bcd_digits_for(input int width);
      return (width * 30103 + 99999) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adj3.sv
// Double-dabble digit correction.
//   d : current BCD digit (4 bits)
//   q : d + 3 when d >= 5, otherwise d
module bcd_adj3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d,
   output logic [BCD_DIGIT_W-1:0] q
);

   always_comb begin
      q = d;
      if (d >= BCD_DIGIT_W'(5)) begin
         q = d + BCD_DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
//   clk, rst_n           : clock; synchronous active-low reset
//   in_valid/in_ready    : input handshake for bin (WIDTH bits)
//   out_valid/out_ready  : output handshake for bcd/negative/overflow
//   bcd                  : DIGITS packed digits, units in bcd[3:0]
//   negative             : input was negative (SIGNED=1 only)
//   overflow             : magnitude needs more than DIGITS digits; bcd then
//                          holds the value modulo 10^DIGITS
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              bin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                          negative,
   output logic                          overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam int BW = BCD_DIGIT_W * DIGITS;

   bcd_state_t       state_r, state_nx;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] mag_r;
   logic [BW-1:0]    bcd_r;
   logic             neg_r;
   logic             ovf_r;

   logic             accept;
   logic             shift;
   logic             bin_neg;
   logic [WIDTH-1:0] bin_mag;
   logic [BW-1:0]    adj;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_adj3 u_adj (
         .d (bcd_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .q (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Two's complement negate in WIDTH bits; the most negative value maps onto
   // itself, which read as unsigned is exactly 2^(WIDTH-1).
   always_comb begin
      bin_neg = (SIGNED != 0) && bin[WIDTH-1];
      bin_mag = bin_neg ? ('0 - bin) : bin;
   end

   always_comb begin
      state_nx  = state_r;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      shift     = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = CONV;
            end
         end
         CONV: begin
            shift = 1'b1;
            if (cnt_r == '0) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         mag_r   <= '0;
         bcd_r   <= '0;
         neg_r   <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         state_r <= state_nx;
         if (accept) begin
            cnt_r <= CW'(WIDTH - 1);
            mag_r <= bin_mag;
            bcd_r <= '0;
            neg_r <= bin_neg;
            ovf_r <= 1'b0;
         end else if (shift) begin
            cnt_r <= cnt_r - 1'b1;
            mag_r <= {mag_r[WIDTH-2:0], 1'b0};
            bcd_r <= {adj[BW-2:0], mag_r[WIDTH-1]};
            // A carry out of the top digit means the true value has more digits.
            if (adj[BW-1]) begin
               ovf_r <= 1'b1;
            end
         end
      end
   end

   assign bcd      = bcd_r;
   assign negative = neg_r;
   assign overflow = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. Three instances share one clock:
//   0: unsigned, 5 digits   1: signed, 5 digits   2: unsigned, 3 digits
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic [2:0]  rn  = '0;
   logic [2:0]  iv  = '0;
   logic [2:0]  orr = '0;
   logic [2:0]  ir;
   logic [2:0]  ovd;
   logic [2:0]  neg;
   logic [2:0]  ovf;
   logic [15:0] bin0 = '0, bin1 = '0, bin2 = '0;
   logic [19:0] bcd0, bcd1;
   logic [11:0] bcd2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u0 (
      .clk(clk), .rst_n(rn[0]), .in_valid(iv[0]), .in_ready(ir[0]), .bin(bin0),
      .out_valid(ovd[0]), .out_ready(orr[0]), .bcd(bcd0), .negative(neg[0]),
      .overflow(ovf[0]));

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u1 (
      .clk(clk), .rst_n(rn[1]), .in_valid(iv[1]), .in_ready(ir[1]), .bin(bin1),
      .out_valid(ovd[1]), .out_ready(orr[1]), .bcd(bcd1), .negative(neg[1]),
      .overflow(ovf[1]));

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(3), .SIGNED(0)) u2 (
      .clk(clk), .rst_n(rn[2]), .in_valid(iv[2]), .in_ready(ir[2]), .bin(bin2),
      .out_valid(ovd[2]), .out_ready(orr[2]), .bcd(bcd2), .negative(neg[2]),
      .overflow(ovf[2]));

   function automatic logic [19:0] bcd_of(input int u);
      case (u)
         0:       return bcd0;
         1:       return bcd1;
         default: return {8'h00, bcd2};
      endcase
   endfunction

   task automatic set_bin(input int u, input logic [15:0] b);
      case (u)
         0:       bin0 = b;
         1:       bin1 = b;
         default: bin2 = b;
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Decimal reference: magnitude by integer arithmetic, digits by /10 and %10.
   task automatic ref_model(input int u, input logic [15:0] b,
                            output logic [19:0] eb, output logic en, output logic eo);
      int unsigned m, v, lim, nd;
      en  = (u == 1) && (b >= 16'h8000);
      m   = en ? (32'd65536 - 32'(b)) : 32'(b);
      nd  = (u == 2) ? 3 : 5;
      lim = (u == 2) ? 1000 : 100000;
      eo  = (m >= lim);
      eb  = '0;
      v   = m;
      for (int unsigned d = 0; d < nd; d++) begin
         eb[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
   endtask

   task automatic convert(input int u, input logic [15:0] b, input int hold);
      logic [19:0] eb, snap;
      logic        en, eo, stable;
      int          cyc;
      ref_model(u, b, eb, en, eo);
      check($sformatf("idle_ready[%0d]", u), 32'(ir[u]), 32'd1);
      iv[u] = 1'b1;
      set_bin(u, b);
      @(posedge clk); #1;
      iv[u] = 1'b0;
      check($sformatf("busy_after_accept[%0d]", u), 32'(ir[u]), 32'd0);
      cyc = 0;
      while (!ovd[u] && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("latency[%0d] bin=%0h", u, b), 32'(cyc), 32'd16);
      check($sformatf("bcd[%0d] bin=%0h", u, b), 32'(bcd_of(u)), 32'(eb));
      check($sformatf("negative[%0d] bin=%0h", u, b), 32'(neg[u]), 32'(en));
      check($sformatf("overflow[%0d] bin=%0h", u, b), 32'(ovf[u]), 32'(eo));
      snap = bcd_of(u);
      for (int i = 0; i < hold; i++) begin
         iv[u] = 1'b1;
         set_bin(u, ~b);
         @(posedge clk); #1;
         stable = ovd[u] && !ir[u] && (bcd_of(u) == snap) && (neg[u] == en) && (ovf[u] == eo);
         check($sformatf("hold[%0d] cycle %0d", u, i), 32'(stable), 32'd1);
      end
      iv[u]  = 1'b0;
      orr[u] = 1'b1;
      @(posedge clk); #1;
      orr[u] = 1'b0;
      check($sformatf("post_handshake_valid[%0d]", u), 32'(ovd[u]), 32'd0);
      check($sformatf("post_handshake_ready[%0d]", u), 32'(ir[u]), 32'd1);
   endtask

   initial begin
      int seen;
      logic [15:0] r;

      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 3; u++) begin
         check($sformatf("rst_in_ready[%0d]", u), 32'(ir[u]), 32'd1);
         check($sformatf("rst_out_valid[%0d]", u), 32'(ovd[u]), 32'd0);
         check($sformatf("rst_bcd[%0d]", u), 32'(bcd_of(u)), 32'd0);
         check($sformatf("rst_flags[%0d]", u), 32'({neg[u], ovf[u]}), 32'd0);
      end
      rn = '1;
      @(posedge clk); #1;

      // Directed cases
      convert(0, 16'd12345, 0);
      convert(1, 16'hFFFF, 0);
      convert(1, 16'h8000, 0);
      convert(2, 16'd1234, 0);
      convert(2, 16'd999, 0);
      convert(1, 16'h0000, 0);
      convert(0, 16'h0000, 0);
      convert(0, 16'hFFFF, 0);
      convert(1, 16'h7FFF, 0);
      convert(2, 16'd1000, 0);

      // Backpressure, then back-to-back words
      convert(0, 16'd40961, 10);
      convert(0, 16'd7, 0);
      convert(1, 16'hC000, 3);

      // Reset at shift 7: accept at edge k, reset sampled at edge k+7
      iv[1] = 1'b1;
      set_bin(1, 16'd54321);
      @(posedge clk); #1;
      iv[1] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rn[1] = 1'b0;
      @(posedge clk); #1;
      check("midconv_rst_in_ready", 32'(ir[1]), 32'd1);
      check("midconv_rst_out_valid", 32'(ovd[1]), 32'd0);
      check("midconv_rst_bcd", 32'(bcd1), 32'd0);
      check("midconv_rst_flags", 32'({neg[1], ovf[1]}), 32'd0);
      rn[1] = 1'b1;
      seen = 0;
      for (int i = 0; i < 24; i++) begin
         @(posedge clk); #1;
         if (ovd[1]) seen++;
      end
      check("midconv_no_spurious_valid", 32'(seen), 32'd0);
      convert(1, 16'd54321, 0);

      // Randomised words on every instance
      for (int i = 0; i < 20; i++) begin
         for (int u = 0; u < 3; u++) begin
            r = 16'($urandom);
            convert(u, r, (i % 7 == 3) ? 2 : 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Iterative, parametrised binary-to-BCD converter that uses shift-and-add-3 (double dabble) and processes one input bit per clock. It accepts signed or unsigned binary words on a valid/ready input and returns packed BCD digits, a sign flag and an overflow flag on a valid/ready output. It sits between the datapath result bus and the seven-segment/display driver, and replaces the fixed 16-bit combinational converter.

## Interface
- `WIDTH`, default 16: input word width, ≥ 2.
- `DIGITS`, default 5: number of BCD digits produced.
- `SIGNED`, default 1: 1 treats `bin` as two's complement; 0 treats it as unsigned.
- `clk`  in  1: clock. One clock domain; all state changes on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `in_valid`  in  1: `bin` is valid.
- `in_ready`  out  1: converter can accept a word.
- `bin`  in  WIDTH: binary input.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: consumer accepts the result.
- `bcd`  out  4*DIGITS: packed digits; digit 0 (units) is in `bcd[3:0]`.
- `negative`  out  1: input was negative. Always 0 when `SIGNED`=0.
- `overflow`  out  1: magnitude needs more than `DIGITS` digits.

## Operation
- States:
  - IDLE: `in_ready`=1. The handshake `in_valid && in_ready` moves to CONV.
  - CONV: runs exactly WIDTH iterations, then moves to DONE.
  - DONE: `out_valid`=1. The handshake `out_valid && out_ready` moves to IDLE.
- On accept:
  - `mag` = (`SIGNED` && `bin[WIDTH-1]`) ? −`bin` : `bin`, computed in WIDTH-bit unsigned arithmetic. The most negative value maps to 2^(WIDTH−1) and is exact.
  - `neg_r` latches the sign.
  - The BCD register and `ovf_r` clear.
  - The iteration counter loads WIDTH−1. It is $clog2(WIDTH) bits wide.
- Each CONV cycle:
  - Every digit ≥ 5 gets +3.
  - Then {bcd, mag} shifts left by 1.
  - Any 1 shifted out of the top digit sets `ovf_r`, which is sticky.
  - The counter decrements; the state leaves CONV when the counter is 0.
- `bcd`, `negative` and `overflow` are registered outputs. They are held stable for the whole of DONE.
- When overflow occurs, `bcd` holds the low `DIGITS` digits of the true value (modulo 10^DIGITS).
- Zero input gives all-zero digits and `negative`=0, including for a signed input of 0.
- `in_ready` is deasserted in CONV and DONE. There is no input buffering and no overlap between conversions.

## Timing
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0; `bcd`=0; `negative`=0; `overflow`=0; counter=0.
- Accept at edge k. Shifts occur at edges k+1 … k+WIDTH. `out_valid` rises after edge k+WIDTH, so latency is WIDTH cycles from accept.
- `in_ready` falls after edge k and rises again the cycle after the output handshake.
- Minimum throughput is one word per WIDTH+2 cycles (accept, WIDTH shifts, output handshake).
- `out_ready` may be held low indefinitely. Outputs are frozen while it is low.
- `in_valid` asserted during CONV or DONE is ignored. The word is not captured until IDLE.
- `rst_n`=0 in any state, including mid-CONV, returns everything to reset values on that edge. The partial result is discarded and no `out_valid` pulse is produced.

## Structure
- Package `bcd_pkg` holds:
  - the state enum `bcd_state_t` {IDLE, CONV, DONE};
  - `BCD_DIGIT_W` = 4;
  - function `bcd_digits_for(width)` (⌈width·log10 2⌉ + 1), used by integrators to size `DIGITS`.
- Sub-module `bcd_adj3`: combinational 4-bit input, 4-bit output; returns d+3 if d ≥ 5, else d. Instantiate it `DIGITS` times in a generate loop.
- The top level holds the FSM, the counter, the magnitude/BCD shift register and the sticky flags.

## Test plan
- Unsigned: `SIGNED`=0, `bin`=16'd12345 → after 16 cycles, digits 4..0 = 1,2,3,4,5; `negative`=0; `overflow`=0.
- Signed: `bin`=16'hFFFF → digits 0,0,0,0,1 with `negative`=1. `bin`=16'h8000 → digits 3,2,7,6,8 with `negative`=1 and `overflow`=0.
- Overflow: `DIGITS`=3, `SIGNED`=0, `bin`=16'd1234 → `bcd`=2,3,4 and `overflow`=1. Then `bin`=16'd999 → 9,9,9 with `overflow`=0 (flag cleared on accept).
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → `bcd` and flags stable, `in_ready`=0, and a new `in_valid` is ignored. `out_ready`=1 → IDLE next cycle; back-to-back words are converted correctly.
- Reset mid-CONV: `rst_n`=0 at shift 7 of 16 → next cycle all outputs are at reset values, `in_ready`=1, and no spurious `out_valid` appears.
- Zero and maximum: `bin`=0 → all digits 0, `negative`=0. `SIGNED`=0, `bin`=16'hFFFF → 6,5,5,3,5.
